shift_ctrl16: RTL and testbench

Sequential front-end for the 16-bit barrel shifter. It latches an operand word and a shift command, drives the shifter's combinational inputs from registers, and captures the shifted word into an output register with a one-cycle valid strobe. It also has an auto-step mode that re-issues the command at a fixed cadence, which produces marquee-style display animation. It sits between the board switch/button logic and the shifter, and its `result_q` feeds the seven-segment/LED display path.

---
 rtl/shift_ctrl16.sv | 75 +++++++
 tb/tb_shift_ctrl16.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shift_ctrl16.sv
// shift_ctrl16: registered front-end for the 16-bit barrel shifter with auto-step marquee mode.
// Optional SHIFT_CTRL_CHAIN_EN: each auto step re-shifts the previous result instead of bumping the amount.
module shift_ctrl16 #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        auto_en,
  input  logic [15:0] sw_data,
  input  logic [3:0]  sw_shamt,
  input  logic        sw_dir,
  input  logic        sw_rotate,
  output logic [15:0] sh_data,
  output logic [3:0]  sh_shamt,
  output logic        sh_dir,
  output logic        sh_rotate,
  input  logic [15:0] sh_result,
  output logic [15:0] result_q,
  output logic        valid,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, APPLY, AUTO} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh_data <= '0;
      sh_shamt <= '0;
      sh_dir <= 1'b0;
      sh_rotate <= 1'b0;
      result_q <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (load) begin
          sh_data <= sw_data;
          sh_shamt <= sw_shamt;
          sh_dir <= sw_dir;
          sh_rotate <= sw_rotate;
          state <= APPLY;
        end
        APPLY: begin
          result_q <= sh_result;
          valid <= 1'b1;
          if (auto_en) begin
            // AUTO lasts TICK_DIV-1 cycles: counts TICK_DIV-2 down to 0 inclusive
            cnt <= CNT_W'(TICK_DIV - 2);
`ifdef SHIFT_CTRL_CHAIN_EN
            sh_data <= sh_result;
`else
            sh_shamt <= sh_shamt + 4'd1;
`endif
            state <= AUTO;
          end else state <= IDLE;
        end
        AUTO: if (load) begin
          sh_data <= sw_data;
          sh_shamt <= sw_shamt;
          sh_dir <= sw_dir;
          sh_rotate <= sw_rotate;
          state <= APPLY;
        end else if (!auto_en) state <= IDLE;
        else if (cnt == '0) state <= APPLY;
        else cnt <= cnt - CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_ctrl16.sv
// tb_shift_ctrl16: directed plus random checks of shift_ctrl16 against an arithmetic shifter model.
module tb_shift_ctrl16;
  logic clk = 0, rst = 1, load = 0, auto_en = 0;
  logic [15:0] sw_data = 0, sh_data, sh_result, result_q;
  logic [3:0] sw_shamt = 0, sh_shamt;
  logic sw_dir = 0, sw_rotate = 0, sh_dir, sh_rotate, valid, busy;
  int vectors = 0, errs = 0;
  logic [15:0] cd, exp_r, held;
  logic [3:0] ca;
  logic cdir, crot;

  always #5 clk = ~clk;

  function automatic logic [15:0] shf(input logic [15:0] d, input logic [3:0] a, input logic r, input logic rot);
    longint v, p, q, lo, hi;
    v = longint'(d);
    p = longint'(1) << a;
    q = longint'(1) << (16 - int'(a));
    lo = r ? v / p : (v * p) % 65536;
    hi = r ? (v * q) % 65536 : v / q;
    return 16'(rot ? lo + hi : lo);
  endfunction

  assign sh_result = shf(sh_data, sh_shamt, sh_dir, sh_rotate);

  shift_ctrl16 #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .auto_en(auto_en),
    .sw_data(sw_data), .sw_shamt(sw_shamt), .sw_dir(sw_dir), .sw_rotate(sw_rotate),
    .sh_data(sh_data), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_rotate(sh_rotate),
    .sh_result(sh_result), .result_q(result_q), .valid(valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] a, input logic r, input logic rot);
    sw_data = d; sw_shamt = a; sw_dir = r; sw_rotate = rot; load = 1;
    tick;
    load = 0;
    check("ld_data", sh_data, d);
    check("ld_shamt", sh_shamt, a);
    check("ld_dir", sh_dir, r);
    check("ld_rot", sh_rotate, rot);
    check("ld_busy", busy, 1);
    cd = d; ca = a; cdir = r; crot = rot;
  endtask

  task automatic model_step;
`ifdef SHIFT_CTRL_CHAIN_EN
    cd = exp_r;
`else
    ca = ca + 4'd1;
`endif
  endtask

  task automatic single(input logic [15:0] d, input logic [3:0] a, input logic r, input logic rot);
    do_load(d, a, r, rot);
    tick;
    check("one_res", result_q, shf(d, a, r, rot));
    check("one_valid", valid, 1);
    check("one_busy", busy, 0);
    tick;
    check("one_valid_off", valid, 0);
  endtask

  initial begin
    tick; tick;
    rst = 0;
    check("rst_data", sh_data, 0);
    check("rst_shamt", sh_shamt, 0);
    check("rst_dir", sh_dir, 0);
    check("rst_rot", sh_rotate, 0);
    check("rst_res", result_q, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    tick;
    check("idle_hold", busy, 0);
    // directed single operations
    single(16'h8001, 4'd1, 1'b0, 1'b1);
    check("rotl_const", result_q, 16'h0003);
    single(16'h8001, 4'd4, 1'b1, 1'b0);
    check("shr_const", result_q, 16'h0800);
    for (int i = 0; i < 16; i++)
      single(16'($urandom), 4'($urandom_range(15)), 1'($urandom), 1'($urandom));
    // load held through APPLY: ignored there, re-triggers once back in IDLE
    sw_data = 16'h00F0; sw_shamt = 4'd2; sw_dir = 0; sw_rotate = 0; load = 1;
    tick;
    sw_data = 16'h0F0F; sw_shamt = 4'd3; sw_dir = 1; sw_rotate = 1;
    tick;
    check("apply_ign_data", sh_data, 16'h00F0);
    check("apply_ign_res", result_q, shf(16'h00F0, 2, 0, 0));
    tick;
    load = 0;
    check("retrig_data", sh_data, 16'h0F0F);
    tick;
    check("retrig_res", result_q, shf(16'h0F0F, 3, 1, 1));
    tick;
    // auto-step marquee: pulses every 4 cycles, 17 steps covers the shamt wrap
    auto_en = 1;
    do_load(16'h0001, 4'd0, 1'b0, 1'b1);
    tick;
    for (int c = 0; c <= 68; c++) begin
      if (c > 0) tick;
      check("auto_valid", valid, (c % 4 == 0) ? 1 : 0);
      check("auto_busy", busy, 1);
      if (c % 4 == 0) begin
        exp_r = shf(cd, ca, cdir, crot);
        check("auto_res", result_q, exp_r);
        model_step;
      end
    end
`ifndef SHIFT_CTRL_CHAIN_EN
    check("auto_wrap", result_q, 16'h0002);
`endif
    held = result_q;
    auto_en = 0;
    tick;
    check("drop_busy", busy, 0);
    check("drop_held", result_q, held);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("drop_novalid", valid, 0);
      check("drop_held2", result_q, held);
    end
    // load arriving mid-AUTO preempts the pending count
    auto_en = 1;
    do_load(16'h0001, 4'd0, 1'b0, 1'b1);
    tick;
    check("mid_first", result_q, 16'h0001);
    tick;
    do_load(16'h1234, 4'd3, 1'b1, 1'b0);
    tick;
    exp_r = shf(cd, ca, cdir, crot);
    check("mid_res", result_q, 16'h0246);
    check("mid_model", result_q, exp_r);
    check("mid_valid", valid, 1);
    model_step;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mid_gap", valid, 0);
    end
    tick;
    check("mid_next_valid", valid, 1);
    check("mid_next_res", result_q, shf(cd, ca, cdir, crot));
    auto_en = 0;
    tick;
    check("mid_idle", busy, 0);
    // reset during APPLY suppresses the capture
    do_load(16'hBEEF, 4'd5, 1'b0, 1'b1);
    rst = 1;
    tick;
    rst = 0;
    check("rapply_valid", valid, 0);
    check("rapply_res", result_q, 0);
    check("rapply_data", sh_data, 0);
    check("rapply_shamt", sh_shamt, 0);
    check("rapply_busy", busy, 0);
    tick;
    check("rapply_valid2", valid, 0);
    check("rapply_res2", result_q, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
